// File: rtl/trap_sequencer.sv
// -----------------------------------------------------------------------------
// trap_sequencer
//
// Sits in front of the machine-mode CSR file and owns its single access port.
// While idle, pipeline CSR accesses pass straight through. When a trap
// (exception or unmasked interrupt) or an mret is accepted, the block takes
// the port for a fixed multi-cycle sequence. Trap entry saves mepc, mcause,
// mtval and an updated mstatus, then reads mtvec. Mret restores mstatus and
// reads mepc. Every sequence ends with a one-cycle redirect pulse to fetch.
//
// Build option:
//   VECTORED_IRQ_EN  when defined, interrupts taken with mtvec[1:0]==2'b01
//                    jump to base + (code << 2). Otherwise every trap jumps
//                    to {mtvec[31:2], 2'b00}.
//
// Ports:
//   clk, rst_n           core clock, asynchronous active-low reset
//   exc_valid/cause/pc/tval   synchronous exception request (level)
//   irq_valid/cause/pc        interrupt request, already masked by mie
//   mret_valid                mret retiring (level)
//   pipe_csr_addr/wdata/we/re pipeline CSR access
//   pipe_csr_rdata            read data returned to the pipeline
//   pipe_stall                pipeline access not serviced this cycle
//   csr_addr/wdata/we/re      CSR file port
//   csr_rdata                 combinational read data from the CSR file
//   busy                      a sequence is in progress
//   redirect_valid            one-cycle pulse: fetch jumps to redirect_pc
//   redirect_pc               trap handler / return target (registered)
// -----------------------------------------------------------------------------
module trap_sequencer #(
    parameter int XLEN    = 32,
    parameter int CAUSE_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               exc_valid,
    input  logic [CAUSE_W-1:0] exc_cause,
    input  logic [XLEN-1:0]    exc_pc,
    input  logic [XLEN-1:0]    exc_tval,
    input  logic               irq_valid,
    input  logic [CAUSE_W-1:0] irq_cause,
    input  logic [XLEN-1:0]    irq_pc,
    input  logic               mret_valid,
    input  logic [11:0]        pipe_csr_addr,
    input  logic [XLEN-1:0]    pipe_csr_wdata,
    input  logic               pipe_csr_we,
    input  logic               pipe_csr_re,
    output logic [XLEN-1:0]    pipe_csr_rdata,
    output logic               pipe_stall,
    output logic [11:0]        csr_addr,
    output logic [XLEN-1:0]    csr_wdata,
    output logic               csr_we,
    output logic               csr_re,
    input  logic [XLEN-1:0]    csr_rdata,
    output logic               busy,
    output logic               redirect_valid,
    output logic [XLEN-1:0]    redirect_pc
);

    localparam logic [3:0] ST_IDLE        = 4'd0;
    localparam logic [3:0] ST_T_RD_STATUS = 4'd1;
    localparam logic [3:0] ST_T_WR_EPC    = 4'd2;
    localparam logic [3:0] ST_T_WR_CAUSE  = 4'd3;
    localparam logic [3:0] ST_T_WR_TVAL   = 4'd4;
    localparam logic [3:0] ST_T_WR_STATUS = 4'd5;
    localparam logic [3:0] ST_T_RD_TVEC   = 4'd6;
    localparam logic [3:0] ST_REDIRECT    = 4'd7;
    localparam logic [3:0] ST_M_RD_STATUS = 4'd8;
    localparam logic [3:0] ST_M_WR_STATUS = 4'd9;
    localparam logic [3:0] ST_M_RD_EPC    = 4'd10;

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MTVAL   = 12'h343;

    logic [3:0]         state_q,       state_d;
    logic               mie_shadow_q,  mie_shadow_d;
    logic               is_irq_q,      is_irq_d;
    logic [CAUSE_W-1:0] code_q,        code_d;
    logic [XLEN-1:0]    pc_q,          pc_d;
    logic [XLEN-1:0]    tval_q,        tval_d;
    logic [XLEN-1:0]    ms_q,          ms_d;
    logic [XLEN-1:0]    redirect_pc_q, redirect_pc_d;

    logic            irq_take;
    logic            req_any;
    logic [XLEN-1:0] cause_word;
    logic [XLEN-1:0] trap_status;
    logic [XLEN-1:0] mret_status;
    logic [XLEN-1:0] tvec_base;
    logic [XLEN-1:0] trap_target;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d        = state_q;
        is_irq_d       = is_irq_q;
        code_d         = code_q;
        pc_d           = pc_q;
        tval_d         = tval_q;
        ms_d           = ms_q;
        redirect_pc_d  = redirect_pc_q;
        csr_addr       = pipe_csr_addr;
        csr_wdata      = pipe_csr_wdata;
        csr_we         = 1'b0;
        csr_re         = 1'b0;
        pipe_csr_rdata = '0;
        pipe_stall     = 1'b1;

        // An interrupt only counts once mstatus.MIE is known to be set.
        irq_take = irq_valid & mie_shadow_q;
        req_any  = exc_valid | mret_valid | irq_take;

        cause_word = {is_irq_q, {(XLEN-1-CAUSE_W){1'b0}}, code_q};

        // Trap entry: MPIE <- MIE, MIE <- 0, MPP <- M.
        trap_status        = ms_q;
        trap_status[7]     = ms_q[3];
        trap_status[3]     = 1'b0;
        trap_status[12:11] = 2'b11;

        // mret: MIE <- MPIE, MPIE <- 1, MPP <- M.
        mret_status        = ms_q;
        mret_status[3]     = ms_q[7];
        mret_status[7]     = 1'b1;
        mret_status[12:11] = 2'b11;

        tvec_base   = {csr_rdata[XLEN-1:2], 2'b00};
        trap_target = tvec_base;
`ifdef VECTORED_IRQ_EN
        if (is_irq_q && (csr_rdata[1:0] == 2'b01)) begin
            // Vector offset wraps at 32 bits like any address add.
            trap_target = tvec_base + {{(XLEN-CAUSE_W-2){1'b0}}, code_q, 2'b00};
        end
`endif

        case (state_q)
            ST_IDLE: begin
                pipe_csr_rdata = csr_rdata;
                if (req_any) begin
                    // The pipeline access is held off; the sequencer takes
                    // the port from the next cycle.
                    if (exc_valid) begin
                        is_irq_d = 1'b0;
                        code_d   = exc_cause;
                        pc_d     = exc_pc;
                        tval_d   = exc_tval;
                        state_d  = ST_T_RD_STATUS;
                    end else if (mret_valid) begin
                        state_d  = ST_M_RD_STATUS;
                    end else begin
                        is_irq_d = 1'b1;
                        code_d   = irq_cause;
                        pc_d     = irq_pc;
                        tval_d   = '0;
                        state_d  = ST_T_RD_STATUS;
                    end
                end else begin
                    pipe_stall = 1'b0;
                    csr_we     = pipe_csr_we;
                    csr_re     = pipe_csr_re;
                end
            end
            ST_T_RD_STATUS: begin
                csr_addr = ADDR_MSTATUS;
                csr_re   = 1'b1;
                ms_d     = csr_rdata;
                state_d  = ST_T_WR_EPC;
            end
            ST_T_WR_EPC: begin
                csr_addr  = ADDR_MEPC;
                csr_wdata = {pc_q[XLEN-1:2], 2'b00};
                csr_we    = 1'b1;
                state_d   = ST_T_WR_CAUSE;
            end
            ST_T_WR_CAUSE: begin
                csr_addr  = ADDR_MCAUSE;
                csr_wdata = cause_word;
                csr_we    = 1'b1;
                state_d   = ST_T_WR_TVAL;
            end
            ST_T_WR_TVAL: begin
                csr_addr  = ADDR_MTVAL;
                csr_wdata = tval_q;
                csr_we    = 1'b1;
                state_d   = ST_T_WR_STATUS;
            end
            ST_T_WR_STATUS: begin
                csr_addr  = ADDR_MSTATUS;
                csr_wdata = trap_status;
                csr_we    = 1'b1;
                state_d   = ST_T_RD_TVEC;
            end
            ST_T_RD_TVEC: begin
                csr_addr      = ADDR_MTVEC;
                csr_re        = 1'b1;
                redirect_pc_d = trap_target;
                state_d       = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                state_d = ST_IDLE;
            end
            ST_M_RD_STATUS: begin
                csr_addr = ADDR_MSTATUS;
                csr_re   = 1'b1;
                ms_d     = csr_rdata;
                state_d  = ST_M_WR_STATUS;
            end
            ST_M_WR_STATUS: begin
                csr_addr  = ADDR_MSTATUS;
                csr_wdata = mret_status;
                csr_we    = 1'b1;
                state_d   = ST_M_RD_EPC;
            end
            ST_M_RD_EPC: begin
                csr_addr      = ADDR_MEPC;
                csr_re        = 1'b1;
                redirect_pc_d = {csr_rdata[XLEN-1:2], 2'b00};
                state_d       = ST_REDIRECT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Keep the CSR file untouched while reset is asserted, even though
        // the idle pass-through would otherwise forward pipeline strobes.
        if (!rst_n) begin
            csr_we = 1'b0;
            csr_re = 1'b0;
        end

        // Shadow of mstatus.MIE follows every write to mstatus, whoever issues it.
        mie_shadow_d = mie_shadow_q;
        if (csr_we && (csr_addr == ADDR_MSTATUS)) begin
            mie_shadow_d = csr_wdata[3];
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            mie_shadow_q  <= 1'b0;
            is_irq_q      <= 1'b0;
            code_q        <= '0;
            pc_q          <= '0;
            tval_q        <= '0;
            ms_q          <= '0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            mie_shadow_q  <= mie_shadow_d;
            is_irq_q      <= is_irq_d;
            code_q        <= code_d;
            pc_q          <= pc_d;
            tval_q        <= tval_d;
            ms_q          <= ms_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign busy           = (state_q != ST_IDLE);
    assign redirect_valid = (state_q == ST_REDIRECT);
    assign redirect_pc    = redirect_pc_q;

endmodule
